stepper_drv: RTL and testbench

STEPPER_DRV -- requirements
Module: stepper_drv

---
 rtl/stepper_drv.sv | 156 +++++++++++++++
 tb/tb_stepper_drv.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stepper_drv.sv
`default_nettype none
// ============================================================================
// Module      : stepper_drv
// Description : Stepper coil sequencer stepping one table phase per step_tick
//               rising edge. Define STEPPER_HALF_STEP_EN for 8-phase half-step.
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_drv #(
   parameter int COIL_IDLE_OFF = 1,
   parameter int STEP_W        = 16
) (
   input  logic              clk,
   input  logic              clk_reset,
   input  logic              step_tick,
   input  logic              start,
   input  logic              dir,
   input  logic [STEP_W-1:0] steps,
   input  logic              abort,
   output logic [3:0]        coil,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] remaining
);

`ifdef STEPPER_HALF_STEP_EN
   localparam int PH_W = 3;
`else
   localparam int PH_W = 2;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              dir_q, dir_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic [3:0]        coil_q, coil_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tick_q;
   logic              w_tick_edge;
   logic [3:0]        w_idle_coil;

   function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] ph);
      logic [3:0] pat;
`ifdef STEPPER_HALF_STEP_EN
      case (ph)
         3'd0:    pat = 4'b1000;
         3'd1:    pat = 4'b1100;
         3'd2:    pat = 4'b0100;
         3'd3:    pat = 4'b0110;
         3'd4:    pat = 4'b0010;
         3'd5:    pat = 4'b0011;
         3'd6:    pat = 4'b0001;
         default: pat = 4'b1001;
      endcase
`else
      case (ph)
         2'd0:    pat = 4'b1100;
         2'd1:    pat = 4'b0110;
         2'd2:    pat = 4'b0011;
         default: pat = 4'b1001;
      endcase
`endif
      return pat;
   endfunction

   assign w_tick_edge = step_tick & ~tick_q;
   // Idle drive either releases the coils or keeps holding torque on the last phase.
   assign w_idle_coil = (COIL_IDLE_OFF != 0) ? 4'b0000 : coil_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      coil_d  = coil_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            coil_d = w_idle_coil;
            if (start) begin
               dir_d = dir;
               rem_d = steps;
               if (steps != '0) begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
                  coil_d  = phase_pattern(phase_q);
               end else begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               coil_d  = w_idle_coil;
            end else if (w_tick_edge) begin
               phase_d = dir_q ? (phase_q + 1'b1) : (phase_q - 1'b1);
               rem_d   = rem_q - 1'b1;
               coil_d  = phase_pattern(phase_d);
               if (rem_q == STEP_W'(1)) begin
                  state_d = S_FINISH;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            coil_d  = w_idle_coil;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            coil_d  = w_idle_coil;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clk_reset) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         dir_q   <= 1'b0;
         rem_q   <= '0;
         coil_q  <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         coil_q  <= coil_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tick_q  <= step_tick;
      end
   end

   assign coil      = coil_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepper_drv
// Description : Directed self-checking bench for stepper_drv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_drv;

   logic        clk = 1'b0;
   logic        clk_reset;
   logic        step_tick;
   logic        start;
   logic        dir;
   logic [15:0] steps;
   logic        abort;
   logic [3:0]  coil;
   logic        busy;
   logic        done;
   logic [15:0] remaining;

   int n_cmp = 0;
   int n_err = 0;

   stepper_drv #(.COIL_IDLE_OFF(1), .STEP_W(16)) dut (
      .clk       (clk),
      .clk_reset (clk_reset),
      .step_tick (step_tick),
      .start     (start),
      .dir       (dir),
      .steps     (steps),
      .abort     (abort),
      .coil      (coil),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One low cycle then one high cycle, so exactly one rising edge is seen.
   task automatic tick();
      step_tick = 1'b0;
      cyc();
      step_tick = 1'b1;
      cyc();
   endtask

   task automatic begin_move(input logic d, input logic [15:0] n);
      dir   = d;
      steps = n;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

`ifdef STEPPER_HALF_STEP_EN
   logic [3:0] half_seq [9] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011,
                                4'b0001, 4'b1001, 4'b1000, 4'b1100};
`else
   logic [3:0] fwd_seq [5] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
   logic [3:0] rev_seq [3] = '{4'b1001, 4'b0011, 4'b0110};
`endif

   initial begin
      clk_reset = 1'b0;
      step_tick = 1'b0;
      start     = 1'b0;
      dir       = 1'b0;
      steps     = 16'd0;
      abort     = 1'b0;
      repeat (3) cyc();
      check("rst_coil", 32'(coil), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_rem", 32'(remaining), 32'h0);
      clk_reset = 1'b1;
      cyc();

`ifdef STEPPER_HALF_STEP_EN
      begin_move(1'b1, 16'd9);
      check("hs_enter_coil", 32'(coil), 32'h8);
      check("hs_enter_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("hs_coil%0d", i), 32'(coil), 32'(half_seq[i]));
         check($sformatf("hs_rem%0d", i), 32'(remaining), 32'(8 - i));
         check($sformatf("hs_done%0d", i), 32'(done), (i == 8) ? 32'h1 : 32'h0);
      end
      check("hs_busy_end", 32'(busy), 32'h0);
      cyc();
      check("hs_idle_coil", 32'(coil), 32'h0);
`else
      // Forward 5 steps from phase 0
      begin_move(1'b1, 16'd5);
      check("fwd_enter_busy", 32'(busy), 32'h1);
      check("fwd_enter_coil", 32'(coil), 32'hC);
      check("fwd_enter_rem", 32'(remaining), 32'd5);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("fwd_coil%0d", i), 32'(coil), 32'(fwd_seq[i]));
         check($sformatf("fwd_rem%0d", i), 32'(remaining), 32'(4 - i));
         check($sformatf("fwd_done%0d", i), 32'(done), (i == 4) ? 32'h1 : 32'h0);
      end
      check("fwd_busy_end", 32'(busy), 32'h0);
      cyc();
      check("fwd_done_clear", 32'(done), 32'h0);
      check("fwd_idle_coil", 32'(coil), 32'h0);

      // Back to phase 0, then reverse 3 steps with 0 -> 3 wrap
      begin_move(1'b0, 16'd1);
      tick();
      check("prep_coil", 32'(coil), 32'hC);
      cyc();
      begin_move(1'b0, 16'd3);
      check("rev_enter_coil", 32'(coil), 32'hC);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rev_coil%0d", i), 32'(coil), 32'(rev_seq[i]));
         check($sformatf("rev_rem%0d", i), 32'(remaining), 32'(2 - i));
      end
      check("rev_done", 32'(done), 32'h1);
      cyc();

      // Zero-step request
      begin_move(1'b1, 16'd0);
      check("zero_done", 32'(done), 32'h1);
      check("zero_busy", 32'(busy), 32'h0);
      check("zero_coil", 32'(coil), 32'h0);
      cyc();
      check("zero_done_clear", 32'(done), 32'h0);
      check("zero_busy_after", 32'(busy), 32'h0);

      // Phase is 1: step back to 0, then 10-step move aborted on 3rd edge
      begin_move(1'b0, 16'd1);
      tick();
      cyc();
      begin_move(1'b1, 16'd10);
      tick();
      check("ab_coil1", 32'(coil), 32'h6);
      dir   = 1'b0;
      steps = 16'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("busy_start_ignored", 32'(busy), 32'h1);
      check("busy_start_rem", 32'(remaining), 32'd9);
      tick();
      check("ab_coil2", 32'(coil), 32'h3);
      step_tick = 1'b0;
      cyc();
      step_tick = 1'b1;
      abort     = 1'b1;
      cyc();
      abort     = 1'b0;
      check("ab_busy", 32'(busy), 32'h0);
      check("ab_done", 32'(done), 32'h0);
      check("ab_rem", 32'(remaining), 32'd8);
      check("ab_coil", 32'(coil), 32'h0);
      begin_move(1'b1, 16'd1);
      check("ab_resume_coil", 32'(coil), 32'h3);
      tick();
      check("ab_next_coil", 32'(coil), 32'h9);
      check("ab_next_done", 32'(done), 32'h1);
      cyc();

      // Phase 3: reset mid-move
      begin_move(1'b1, 16'd4);
      tick();
      check("mr_coil", 32'(coil), 32'hC);
      clk_reset = 1'b0;
      cyc();
      cyc();
      check("mr_rst_coil", 32'(coil), 32'h0);
      check("mr_rst_busy", 32'(busy), 32'h0);
      check("mr_rst_rem", 32'(remaining), 32'h0);
      clk_reset = 1'b1;
      cyc();
      check("mr_rel_done", 32'(done), 32'h0);
      check("mr_rel_coil", 32'(coil), 32'h0);
      begin_move(1'b1, 16'd1);
      check("mr_enter_coil", 32'(coil), 32'hC);
      tick();
      check("mr_step_coil", 32'(coil), 32'h6);
      check("mr_step_done", 32'(done), 32'h1);
      cyc();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
